// File: rtl/seq_pattern_tx_pkg.sv
// rtl/seq_pattern_tx_pkg.sv - shared types and constants for the serial pattern transmitter
package seq_pattern_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    localparam logic       DEF_IDLE_BIT = 1'b1;
    // Pattern recognised by the seq_dec_001 detector.
    localparam logic [2:0] PAT_001      = 3'b001;

endpackage

// File: rtl/seq_pattern_tx_shifter.sv
// rtl/seq_pattern_tx_shifter.sv - loadable MSB-first shift register with a last-bit flag
module pat_shifter #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [PAT_W-1:0] i_data,
    output logic             o_next_bit,
    output logic             o_last
);

    localparam int BCW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    logic [PAT_W-1:0] r_sh;
    logic [BCW-1:0]   r_cnt;
    logic [PAT_W-1:0] w_shifted;

    assign w_shifted  = r_sh << 1;
    // Bit that will be on the line once the current one has been shifted out.
    assign o_next_bit = w_shifted[PAT_W-1];
    assign o_last     = (r_cnt == BCW'(PAT_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_data;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sh  <= w_shifted;
            r_cnt <= r_cnt + BCW'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - repeating MSB-first serial pattern transmitter with inter-frame gap
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int   PAT_W    = 3,
    parameter int   CNT_W    = 4,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             dout,
    output logic             dout_vld,
    output logic             frame_sof,
    output logic             busy,
    output logic             done
);

    state_t           r_state, w_state_nxt;
    logic [PAT_W-1:0] r_pat;
    logic [CNT_W-1:0] r_rep, w_rep_nxt;
    logic [GAP_W-1:0] r_gap, r_gcnt, w_gcnt_nxt;
    logic             r_dout, r_vld, r_sof, r_busy, r_done;
    logic             w_dout_nxt, w_vld_nxt, w_sof_nxt, w_busy_nxt, w_done_nxt;
    logic             w_latch, w_load, w_shift, w_next_bit, w_last;
    logic [PAT_W-1:0] w_load_data;

    pat_shifter #(.PAT_W(PAT_W)) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (w_load_data),
        .o_next_bit (w_next_bit),
        .o_last     (w_last)
    );

    // Outputs are computed one cycle ahead so every output leaves a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_dout_nxt  = IDLE_BIT;
        w_vld_nxt   = 1'b0;
        w_sof_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_load_data = r_pat;
        w_rep_nxt   = r_rep;
        w_gcnt_nxt  = r_gcnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_latch     = 1'b1;
                    w_load      = 1'b1;
                    w_load_data = pattern;
                    w_state_nxt = SEND;
                    w_dout_nxt  = pattern[PAT_W-1];
                    w_vld_nxt   = 1'b1;
                    w_sof_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (!w_last) begin
                    w_shift    = 1'b1;
                    w_dout_nxt = w_next_bit;
                    w_vld_nxt  = 1'b1;
                    w_busy_nxt = 1'b1;
                end else if (r_rep > CNT_W'(1)) begin
                    w_rep_nxt  = r_rep - CNT_W'(1);
                    w_busy_nxt = 1'b1;
                    if (r_gap != '0) begin
                        w_state_nxt = GAP;
                        w_gcnt_nxt  = r_gap;
                    end else begin
                        w_load     = 1'b1;
                        w_dout_nxt = r_pat[PAT_W-1];
                        w_vld_nxt  = 1'b1;
                        w_sof_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_gcnt <= GAP_W'(1)) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                    w_dout_nxt  = r_pat[PAT_W-1];
                    w_vld_nxt   = 1'b1;
                    w_sof_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_gcnt_nxt = r_gcnt - GAP_W'(1);
                    w_busy_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_rep   <= '0;
            r_gap   <= '0;
            r_gcnt  <= '0;
            r_dout  <= IDLE_BIT;
            r_vld   <= 1'b0;
            r_sof   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_dout  <= w_dout_nxt;
            r_vld   <= w_vld_nxt;
            r_sof   <= w_sof_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_pat <= pattern;
                r_rep <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                r_gap <= gap;
            end else begin
                r_rep <= w_rep_nxt;
            end
        end
    end

    assign dout      = r_dout;
    assign dout_vld  = r_vld;
    assign frame_sof = r_sof;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;
    import seq_pattern_tx_pkg::*;

    localparam int PW = 3;
    localparam int CW = 4;
    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [PW-1:0] pattern;
    logic [CW-1:0] repeat_n;
    logic [GW-1:0] gap;
    logic          dout, dout_vld, frame_sof, busy, done;

    int total = 0;
    int bad   = 0;
    int busy_cnt, sof_cnt, done_cyc, det_cnt;
    logic [2:0] hist;
    logic [4:0] exp_q[$];

    typedef struct {
        logic [PW-1:0] pat;
        logic [CW-1:0] rep;
        logic [GW-1:0] gp;
        int            exp_busy;
        int            exp_sof;
        int            exp_done;
    } vec_t;

    vec_t vecs[7];

    seq_pattern_tx #(.PAT_W(PW), .CNT_W(CW), .GAP_W(GW), .IDLE_BIT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .repeat_n  (repeat_n),
        .gap       (gap),
        .abort     (abort),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .frame_sof (frame_sof),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {dout, dout_vld, frame_sof, busy, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the visible cycle sequence of a whole transmission, {dout,vld,sof,busy,done}.
    task automatic build_model(input logic [PW-1:0] p, input int rep, input int g);
        int frames;
        frames = (rep == 0) ? 1 : rep;
        exp_q.delete();
        for (int f = 0; f < frames; f++) begin
            for (int b = 0; b < PW; b++)
                exp_q.push_back({p[PW-1-b], 1'b1, (b == 0), 1'b1, 1'b0});
            if (f < frames - 1)
                for (int k = 0; k < g; k++) exp_q.push_back(5'b10010);
        end
        exp_q.push_back(5'b10001);
    endtask

    task automatic launch(input logic [PW-1:0] p, input int rep, input int g);
        build_model(p, rep, g);
        pattern  = p;
        repeat_n = CW'(rep);
        gap      = GW'(g);
        start    = 1'b1;
        hist     = 3'b111;
    endtask

    // Walks the model sequence; optionally pulses start again after cycle resend_at.
    task automatic play(input string tag, input int resend_at);
        busy_cnt = 0;
        sof_cnt  = 0;
        done_cyc = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            start    = ((i + 1) == resend_at);
            pattern  = PW'($urandom);
            repeat_n = CW'($urandom);
            gap      = GW'($urandom);
            check($sformatf("%s cyc%0d", tag, i + 1), obs(), exp_q[i]);
            busy_cnt += int'(busy);
            sof_cnt  += int'(frame_sof);
            if (done) done_cyc = i + 1;
            hist = {hist[1:0], dout};
            if (hist == PAT_001) det_cnt++;
        end
    endtask

    task automatic idle_check(input string name);
        start = 1'b0;
        tick();
        check(name, obs(), 5'b10000);
    endtask

    initial begin
        vecs[0] = '{3'b001, 4'd1, 4'd0,  3,  1,  4};
        vecs[1] = '{3'b001, 4'd2, 4'd0,  6,  2,  7};
        vecs[2] = '{3'b001, 4'd2, 4'd3,  9,  2, 10};
        vecs[3] = '{3'b101, 4'd0, 4'd0,  3,  1,  4};
        vecs[4] = '{3'b110, 4'd3, 4'd1, 11,  3, 12};
        vecs[5] = '{3'b011, 4'd4, 4'd15, 57, 4, 58};
        vecs[6] = '{3'b111, 4'd15, 4'd0, 45, 15, 46};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; repeat_n = '0; gap = '0;
        det_cnt = 0; hist = 3'b111;
        tick();
        tick();
        check("reset", obs(), 5'b10000);
        rst = 1'b0;
        idle_check("idle_after_reset");

        for (int v = 0; v < 7; v++) begin
            launch(vecs[v].pat, int'(vecs[v].rep), int'(vecs[v].gp));
            play($sformatf("vec%0d", v), -1);
            check($sformatf("vec%0d busy_cycles", v), busy_cnt, vecs[v].exp_busy);
            check($sformatf("vec%0d sof_count", v), sof_cnt, vecs[v].exp_sof);
            check($sformatf("vec%0d done_cycle", v), done_cyc, vecs[v].exp_done);
            idle_check($sformatf("vec%0d idle", v));
        end

        det_cnt = 0;
        launch(PAT_001, 2, 0);
        play("loopback", -1);
        check("loopback det_count", det_cnt, 2);
        idle_check("loopback idle");

        launch(PAT_001, 0, 0);
        play("busy_start", 2);
        check("busy_start sof_count", sof_cnt, 1);
        idle_check("busy_start idle");

        launch(PAT_001, 1, 0);
        tick();
        start = 1'b0;
        check("abort cyc1", obs(), 5'b01110);
        tick();
        check("abort cyc2", obs(), 5'b01010);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort cyc3", obs(), 5'b10000);
        tick();
        check("abort no_done", obs(), 5'b10000);
        launch(PAT_001, 1, 0);
        play("after_abort", -1);
        check("after_abort busy_cycles", busy_cnt, 3);
        idle_check("after_abort idle");

        launch(PAT_001, 2, 3);
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
        end
        check("rst_gap cyc4", obs(), 5'b10010);
        rst   = 1'b1;
        abort = 1'b1;
        tick();
        rst   = 1'b0;
        abort = 1'b0;
        check("rst_gap reset", obs(), 5'b10000);
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("rst_gap quiet%0d", c), obs(), 5'b10000);
        end

        launch(PAT_001, 1, 0);
        play("chain_a", -1);
        launch(3'b110, 1, 0);
        play("chain_b", -1);
        check("chain_b first_bit_cycle", busy_cnt, 3);
        idle_check("chain idle");

        for (int r = 0; r < 25; r++) begin
            logic [PW-1:0] p;
            int            rp, g, frames;
            p      = PW'($urandom_range(0, 7));
            rp     = int'($urandom_range(0, 6));
            g      = int'($urandom_range(0, 4));
            frames = (rp == 0) ? 1 : rp;
            launch(p, rp, g);
            play($sformatf("rand%0d", r), -1);
            check($sformatf("rand%0d busy_cycles", r), busy_cnt, frames * PW + (frames - 1) * g);
            idle_check($sformatf("rand%0d idle", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
